// File: rtl/leaf_uplink_if.sv
// -----------------------------------------------------------------------------
// leaf_uplink_if
// Handshake bundle between the per-leaf NI requesters, the uplink arbiter
// and the group router.
//   req_data  [N_REQ*DATA_W] : flit from requester i at [i*DATA_W +: DATA_W]
//   req_valid [N_REQ]        : requester i presents a flit
//   req_ready [N_REQ]        : requester i's flit is taken when valid&ready
//   up_data   [DATA_W]       : registered flit towards the router
//   up_valid                 : up_data holds a flit
//   up_ready                 : router takes the flit when up_valid&up_ready
// Modports: master = arbiter side, slave = requesters/router side.
// -----------------------------------------------------------------------------
interface leaf_uplink_if #(
    parameter int DATA_W = 16,
    parameter int N_REQ  = 4
);
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       up_data;
    logic                    up_valid;
    logic                    up_ready;

    modport master (
        input  req_data, req_valid, up_ready,
        output req_ready, up_data, up_valid
    );

    modport slave (
        output req_data, req_valid, up_ready,
        input  req_ready, up_data, up_valid
    );
endinterface

// File: rtl/leaf_uplink_arbiter.sv
// -----------------------------------------------------------------------------
// leaf_uplink_arbiter
// Round-robin arbiter merging N_REQ leaf NI flit streams onto one registered
// uplink. A requester keeps the grant for up to BURST_MAX flits or until it
// drops valid; each tenure is followed by a one-cycle IDLE arbitration bubble.
// Flit contents are passed through untouched.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   bus        : leaf_uplink_if.master (requester and uplink handshakes)
//   grant_id   : current owner, meaningful only while busy=1
//   busy       : arbiter is in a grant tenure
//   stat_flits : (only with LEAF_ARB_STATS_EN) per-requester 16-bit
//                saturating count of accepted flits at [i*16 +: 16]
// Optional feature macro: LEAF_ARB_STATS_EN
// -----------------------------------------------------------------------------
module leaf_uplink_arbiter #(
    parameter int  DATA_W    = 16,
    parameter int  N_REQ     = 4,
    parameter int  BURST_MAX = 4,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    leaf_uplink_if.master   bus,
    output logic [ID_W-1:0] grant_id,
    output logic            busy
`ifdef LEAF_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] stat_flits
`endif
);

    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   owner_reg;
    logic [3:0]        burst_cnt_reg;
    logic              up_valid_reg;
    logic [DATA_W-1:0] up_data_reg;

    // Per-requester view of the flattened data bus.
    logic [DATA_W-1:0] req_flit [N_REQ];
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_flit
        assign req_flit[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    logic            owner_valid;
    logic            up_slot_free;
    logic            accept;
    logic            burst_last;
    logic [ID_W-1:0] owner_next;

    assign owner_valid  = bus.req_valid[owner_reg];
    // The output register can take a flit if empty or being drained now.
    assign up_slot_free = !up_valid_reg || bus.up_ready;
    assign accept       = (state_reg == GRANT) && owner_valid && up_slot_free;
    assign burst_last   = (burst_cnt_reg + 4'd1) == BURST_MAX_C;
    assign owner_next   = (owner_reg == ID_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

    // Round-robin search starting at rr_ptr. Iterating from the farthest
    // candidate down lets the nearest valid requester overwrite the result.
    logic            hit;
    logic [ID_W-1:0] hit_idx;
    always_comb begin : search
        int              cand;
        logic [ID_W-1:0] cand_id;
        hit     = 1'b0;
        hit_idx = '0;
        cand    = 0;
        cand_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_id = ID_W'(cand);
            if (bus.req_valid[cand_id]) begin
                hit     = 1'b1;
                hit_idx = cand_id;
            end
        end
    end

    // Only the owner sees ready, and only while in GRANT.
    logic [N_REQ-1:0] req_ready_next;
    always_comb begin
        req_ready_next = '0;
        if (state_reg == GRANT) begin
            req_ready_next[owner_reg] = up_slot_free;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            up_valid_reg  <= 1'b0;
            up_data_reg   <= '0;
        end else begin
            // Output register: load on accept, otherwise clear once drained.
            // It is independent of the FSM so a stalled flit survives the
            // return to IDLE.
            if (accept) begin
                up_data_reg  <= req_flit[owner_reg];
                up_valid_reg <= 1'b1;
            end else if (up_valid_reg && bus.up_ready) begin
                up_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        owner_reg     <= hit_idx;
                        burst_cnt_reg <= '0;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_valid) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= owner_next;
                    end else if (accept) begin
                        burst_cnt_reg <= burst_cnt_reg + 4'd1;
                        if (burst_last) begin
                            state_reg  <= IDLE;
                            rr_ptr_reg <= owner_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_next;
    assign bus.up_data   = up_data_reg;
    assign bus.up_valid  = up_valid_reg;
    assign grant_id      = owner_reg;
    assign busy          = (state_reg == GRANT);

`ifdef LEAF_ARB_STATS_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (accept && (owner_reg == ID_W'(gi)) && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
        assign stat_flits[gi*16 +: 16] = cnt_reg;
    end
`endif

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for leaf_uplink_arbiter.
// Each phase preloads per-requester flit queues while reset is held; a
// tenure-level round-robin model turns those queues into the expected order
// of accepted sources and uplink flits. Monitors compare DUT handshakes
// against those expectations independently of the stimulus driver.
// -----------------------------------------------------------------------------
module tb_leaf_uplink_arbiter;

    localparam int DATA_W    = 16;
    localparam int N_REQ     = 4;
    localparam int BURST_MAX = 4;
    localparam int ID_W      = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_uplink_if #(.DATA_W(DATA_W), .N_REQ(N_REQ)) bus ();
    logic [ID_W-1:0] grant_id;
    logic            busy;
`ifdef LEAF_ARB_STATS_EN
    logic [N_REQ*16-1:0] stat_flits;
`endif

    leaf_uplink_arbiter #(
        .DATA_W    (DATA_W),
        .N_REQ     (N_REQ),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef LEAF_ARB_STATS_EN
        ,
        .stat_flits (stat_flits)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Stimulus source queues and scoreboard queues.
    logic [15:0] src_q [N_REQ][$];
    int          exp_src [$];
    bit          exp_new [$];
    logic [15:0] exp_data [$];
    int          loaded [N_REQ];

    int      ready_mode = 1;   // 0: random, 1: always ready, 2: never ready
    bit      gap_chk    = 1'b0;
    bit      have_prev  = 1'b0;
    longint  prev_cyc   = 0;
    longint  cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tenure-level reference: starting from priority 0, the first requester
    // with flits left gets min(BURST_MAX, remaining) flits, then priority
    // moves just past it.
    task automatic build_model();
        int pos [N_REQ];
        int total;
        int ptr;
        int pick;
        int n;
        total = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos[i]    = 0;
            loaded[i] = src_q[i].size();
            total    += src_q[i].size();
        end
        ptr = 0;
        while (total > 0) begin
            pick = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (pick < 0 && pos[(ptr + k) % N_REQ] < src_q[(ptr + k) % N_REQ].size())
                    pick = (ptr + k) % N_REQ;
            end
            n = src_q[pick].size() - pos[pick];
            if (n > BURST_MAX) n = BURST_MAX;
            for (int j = 0; j < n; j++) begin
                exp_src.push_back(pick);
                exp_new.push_back(j == 0);
                exp_data.push_back(src_q[pick][pos[pick] + j]);
            end
            pos[pick] += n;
            total     -= n;
            ptr = (pick + 1) % N_REQ;
        end
    endtask

    // Driver: present queue heads on the falling edge, retire on handshake.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.up_ready  = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                bus.req_valid[i] = (src_q[i].size() > 0);
                bus.req_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0000;
            end
            case (ready_mode)
                0:       bus.up_ready = ($urandom_range(0, 3) != 0);
                1:       bus.up_ready = 1'b1;
                default: bus.up_ready = 1'b0;
            endcase
            #1;
            if (!reset) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
                end
            end
        end
    end

    // Accept monitor: source order, grant_id, tenure bubble spacing.
    initial begin
        int  s;
        bit  nt;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (!busy) check("ready_idle", 32'(bus.req_ready), 0);
                for (int i = 0; i < N_REQ; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        if (exp_src.size() == 0) begin
                            check("accept_unexpected", i, 32'hFFFF_FFFF);
                        end else begin
                            s  = exp_src.pop_front();
                            nt = exp_new.pop_front();
                            check("accept_src", i, s);
                            check("grant_id", 32'(grant_id), i);
                            if (gap_chk && have_prev)
                                check("accept_gap", 32'(cyc - prev_cyc), nt ? 2 : 1);
                            prev_cyc  = cyc;
                            have_prev = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output monitor: flit order/value and stability under backpressure.
    initial begin
        bit          hold_pending = 1'b0;
        logic [15:0] hold_data    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (hold_pending) begin
                    check("hold_valid", 32'(bus.up_valid), 1);
                    check("hold_data", 32'(bus.up_data), 32'(hold_data));
                end
                if (bus.up_valid && !bus.up_ready)
                    check("stall_ready", 32'(bus.req_ready), 0);
                hold_pending = bus.up_valid && !bus.up_ready;
                hold_data    = bus.up_data;
                if (bus.up_valid && bus.up_ready) begin
                    if (exp_data.size() == 0)
                        check("up_unexpected", 32'(bus.up_data), 32'hFFFF_FFFF);
                    else
                        check("up_data", 32'(bus.up_data), 32'(exp_data.pop_front()));
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    // Assert reset (asynchronous), verify cleared outputs, flush queues.
    task automatic reset_begin(input string tag);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check({tag, "_rst_up_valid"}, 32'(bus.up_valid), 0);
        check({tag, "_rst_busy"}, 32'(busy), 0);
        check({tag, "_rst_grant_id"}, 32'(grant_id), 0);
        check({tag, "_rst_req_ready"}, 32'(bus.req_ready), 0);
        check({tag, "_rst_up_data"}, 32'(bus.up_data), 0);
`ifdef LEAF_ARB_STATS_EN
        check({tag, "_rst_stats"}, 32'(stat_flits == '0), 1);
`endif
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        exp_src.delete();
        exp_new.delete();
        exp_data.delete();
        have_prev = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_end(input int mode, input bit gap);
        build_model();
        ready_mode = mode;
        gap_chk    = gap;
        @(negedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && (exp_data.size() > 0 || exp_src.size() > 0); c++)
            @(negedge clk);
        check({tag, "_drain_left"}, exp_data.size() + exp_src.size(), 0);
        repeat (3) @(negedge clk);
`ifdef LEAF_ARB_STATS_EN
        for (int i = 0; i < N_REQ; i++)
            check({tag, "_stat"}, 32'(stat_flits[i*16 +: 16]), loaded[i]);
`endif
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All four requesters continuously valid, router always ready.
        reset_begin("a");
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < 8; j++) src_q[i].push_back(16'($urandom));
        reset_end(1, 1'b1);
        drain("a", 200);

        // Single requester longer than one burst; header bits untouched.
        reset_begin("b");
        for (int j = 1; j <= 6; j++) src_q[2].push_back(16'h7C00 + 16'(j));
        reset_end(1, 1'b1);
        drain("b", 100);

        // Owner 0 runs out after two flits; requester 3 follows.
        reset_begin("c");
        src_q[0].push_back(16'hA001);
        src_q[0].push_back(16'hA002);
        for (int j = 0; j < 3; j++) src_q[3].push_back(16'hD000 + 16'(j));
        reset_end(0, 1'b0);
        drain("c", 100);

        // Random loads with random backpressure.
        for (int p = 0; p < 4; p++) begin
            reset_begin("r");
            for (int i = 0; i < N_REQ; i++) begin
                int n;
                n = $urandom_range(0, 10);
                for (int j = 0; j < n; j++) src_q[i].push_back(16'($urandom));
            end
            reset_end(0, 1'b0);
            drain("r", 400);
        end

        // Stall with flit 0x1234 held, then release.
        reset_begin("s");
        src_q[1].push_back(16'h1234);
        src_q[1].push_back(16'h5678);
        src_q[1].push_back(16'h9ABC);
        reset_end(2, 1'b0);
        repeat (7) @(negedge clk);
        #3;
        check("stall_up_valid", 32'(bus.up_valid), 1);
        check("stall_up_data", 32'(bus.up_data), 32'h1234);
        check("stall_owner", 32'(grant_id), 1);
        ready_mode = 1;
        drain("s", 100);

        // Reset while a flit sits in the output register, then restart from 0.
        reset_begin("m");
        src_q[3].push_back(16'hBEEF);
        src_q[3].push_back(16'hCAFE);
        reset_end(2, 1'b0);
        repeat (4) @(negedge clk);
        #3;
        check("mid_pre_up_valid", 32'(bus.up_valid), 1);
        reset_begin("m2");
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < 2; j++) src_q[i].push_back(16'($urandom));
        reset_end(1, 1'b0);
        drain("m2", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
